// File: rtl/debug_phy_shift.sv
// rtl/debug_phy_shift.sv - half-duplex remote-debug PHY shift engine
// Serializes write words onto DO/DOE, or turns the pin around and deserializes a read word from DI.
module debug_phy_shift #(
    parameter int DW = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  WR,
    input  logic [$clog2(DW)-1:0] NBITS,
    input  logic [1:0]            TURN,
    input  logic [DW-1:0]         WDATA,
    output logic                  RESP_VALID,
    output logic [DW-1:0]         RDATA,
    output logic                  DO,
    output logic                  DOE,
    input  logic                  DI
);

    localparam int IW = $clog2(DW);
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TX    = 3'd1,
        S_TURN1 = 3'd2,
        S_RX    = 3'd3,
        S_TURN2 = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] n_q, n_d;
    logic [2:0]    t_q, t_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          do_q, do_d;
    logic          doe_q, doe_d;

    logic          accept;
    logic          last_cycle;
    logic [CW-1:0] nbits_ext;
    logic [2:0]    turn_ext;
    logic [IW-1:0] rx_idx;

    assign accept     = req_ready_q && REQ_VALID;
    assign last_cycle = (cnt_q == CW'(1));
    assign nbits_ext  = (NBITS == '0) ? CW'(DW) : {1'b0, NBITS};
    assign turn_ext   = {1'b0, TURN} + 3'd1;
    // Counter runs N..1 during RX, so the sample index climbs 0..N-1.
    assign rx_idx     = IW'(n_q - cnt_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            n_q          <= '0;
            t_q          <= '0;
            shift_q      <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            do_q         <= 1'b0;
            doe_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            t_q          <= t_d;
            shift_q      <= shift_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            do_q         <= do_d;
            doe_q        <= doe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        t_d     = t_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    n_d     = nbits_ext;
                    t_d     = turn_ext;
                    shift_d = WR ? WDATA : '0;
                    if (WR) begin
                        state_d = S_TX;
                        cnt_d   = nbits_ext;
                    end else begin
                        state_d = S_TURN1;
                        cnt_d   = {{(CW-3){1'b0}}, turn_ext};
                    end
                end
            end
            S_TX: begin
                shift_d = shift_q >> 1;
                if (last_cycle) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_TURN1: begin
                if (last_cycle) begin
                    state_d = S_RX;
                    cnt_d   = n_q;
                end
            end
            S_RX: begin
                shift_d[rx_idx] = DI;
                // The final sample lands in the same edge that publishes the word.
                if (last_cycle) begin
                    state_d = S_TURN2;
                    cnt_d   = {{(CW-3){1'b0}}, t_q};
                    rdata_d = shift_d;
                end
            end
            S_TURN2: begin
                if (last_cycle) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so the pin changes with the state itself.
    always_comb begin
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_DONE);
        doe_d        = (state_d == S_TX);
        do_d         = (state_d == S_TX) && shift_d[0];
    end

    assign REQ_READY  = req_ready_q;
    assign RESP_VALID = resp_valid_q;
    assign RDATA      = rdata_q;
    assign DO         = do_q;
    assign DOE        = doe_q;

endmodule

// File: tb/tb_debug_phy_shift.sv
// tb/tb_debug_phy_shift.sv - scoreboard bench for debug_phy_shift
// Cycle c spans from edge c-1 to edge c; a request accepted at edge t shapes cycles t+1 onward.
module tb_debug_phy_shift;

    localparam int DW   = 32;
    localparam int MAXC = 4096;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          WR;
    logic [4:0]    NBITS;
    logic [1:0]    TURN;
    logic [DW-1:0] WDATA;
    logic          RESP_VALID;
    logic [DW-1:0] RDATA;
    logic          DO;
    logic          DOE;
    logic          DI;

    debug_phy_shift #(.DW(DW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .WR         (WR),
        .NBITS      (NBITS),
        .TURN       (TURN),
        .WDATA      (WDATA),
        .RESP_VALID (RESP_VALID),
        .RDATA      (RDATA),
        .DO         (DO),
        .DOE        (DOE),
        .DI         (DI)
    );

    always #5 CLK = ~CLK;

    int cyc = 1;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          wr;
        logic [31:0] rdata;
    } resp_t;

    resp_t       sb[$];
    bit          exp_busy [MAXC];
    bit          exp_doe  [MAXC];
    bit          exp_do   [MAXC];
    bit          di_arr   [MAXC];
    logic [31:0] exp_rdata[MAXC];
    int          dut_acc_cyc[$];

    int checks    = 0;
    int failures  = 0;
    int dut_acc   = 0;
    int model_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic idle(input int k);
        REQ_VALID = 1'b0;
        repeat (k) @(negedge CLK);
    endtask

    // Presents a request at the current negedge and holds it until the model says it is taken.
    task automatic issue(input int wr, input int nb, input int tn,
                         input logic [31:0] wd, input logic [31:0] rd, output int acc);
        int          a;
        int          n;
        int          tt;
        logic [31:0] val;
        REQ_VALID = 1'b1;
        WR        = (wr != 0);
        NBITS     = nb[4:0];
        TURN      = tn[1:0];
        WDATA     = wd;
        a = cyc;
        while (exp_busy[a]) a++;
        while (cyc < a) @(negedge CLK);
        model_acc++;
        acc = a;
        n  = (nb[4:0] == 5'd0) ? DW : int'(nb[4:0]);
        tt = int'(tn[1:0]) + 1;
        if (wr != 0) begin
            for (int i = 0; i < n; i++) begin
                exp_doe[a+1+i] = 1'b1;
                exp_do[a+1+i]  = wd[i];
            end
            for (int k = a + 1; k <= a + n + 1; k++) exp_busy[k] = 1'b1;
            sb.push_back('{cyc: a + n + 1, wr: 1'b1, rdata: 32'h0});
        end else begin
            val = '0;
            for (int i = 0; i < n; i++) begin
                di_arr[a+tt+1+i] = rd[i];
                val[i]           = rd[i];
            end
            for (int k = a + 1; k <= a + 2*tt + n + 1; k++) exp_busy[k] = 1'b1;
            for (int k = a + tt + n + 1; k < MAXC; k++) exp_rdata[k] = val;
            sb.push_back('{cyc: a + 2*tt + n + 1, wr: 1'b0, rdata: val});
        end
        @(negedge CLK);
    endtask

    // Reset sampled at the edge ending cycle c wipes everything from cycle c+1 on.
    task automatic model_reset(input int c);
        while (sb.size() > 0 && sb[$].cyc > c) void'(sb.pop_back());
        for (int k = c + 1; k < MAXC; k++) begin
            exp_busy[k]  = 1'b0;
            exp_doe[k]   = 1'b0;
            exp_do[k]    = 1'b0;
            exp_rdata[k] = '0;
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            DI = di_arr[cyc % MAXC];
        end
    end

    initial begin
        int c;
        forever begin
            @(negedge CLK);
            #1;
            c = cyc;
            if (c >= 2 && c < MAXC) begin
                chk("req_ready", {31'b0, REQ_READY}, {31'b0, !exp_busy[c]});
                chk("doe", {31'b0, DOE}, {31'b0, exp_doe[c]});
                chk("do", {31'b0, DO}, {31'b0, exp_do[c]});
                chk("rdata", RDATA, exp_rdata[c]);
                while (sb.size() > 0 && sb[0].cyc < c) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_missing cycle=%0d expected_resp_cycle=%0d", c, sb[0].cyc);
                    void'(sb.pop_front());
                end
                if (RESP_VALID) begin
                    checks++;
                    if (sb.size() > 0 && sb[0].cyc == c) begin
                        if (!sb[0].wr) chk("resp_rdata", RDATA, sb[0].rdata);
                        void'(sb.pop_front());
                    end else begin
                        failures++;
                        $display("FAIL resp_spurious cycle=%0d actual=1 expected=0", c);
                    end
                end
                if (REQ_VALID && REQ_READY && !RESET) begin
                    dut_acc++;
                    dut_acc_cyc.push_back(c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int w;
        for (int k = 0; k < MAXC; k++) begin
            exp_rdata[k] = '0;
            di_arr[k]    = 1'($urandom_range(0, 1));
        end
        RESET     = 1'b1;
        REQ_VALID = 1'b0;
        WR        = 1'b0;
        NBITS     = '0;
        TURN      = '0;
        WDATA     = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        idle(2);

        issue(1, 8, 2, 32'h0000_00A5, 32'h0, acc);
        idle(2);
        issue(0, 4, 1, $urandom, 32'hFFFF_FFFB, acc);
        idle(1);
        issue(0, 0, 0, $urandom, 32'hDEAD_BEEF, acc);
        idle(3);

        issue(1, 3, 0, $urandom, 32'h0, acc);
        issue(1, 5, 3, $urandom, 32'h0, acc);
        idle(1);
        if (dut_acc_cyc.size() >= 2)
            chk("b2b_gap", 32'(dut_acc_cyc[$] - dut_acc_cyc[$-1]), 32'd5);
        else begin
            checks++;
            failures++;
            $display("FAIL b2b_gap accepts_seen=%0d expected=2", dut_acc_cyc.size());
        end
        idle(8);

        issue(0, 16, 1, $urandom, $urandom, acc);
        REQ_VALID = 1'b0;
        while (cyc < acc + 2 + 3) @(negedge CLK);
        RESET = 1'b1;
        model_reset(cyc);
        @(negedge CLK);
        RESET = 1'b0;
        issue(1, 8, 0, $urandom, 32'h0, acc);
        idle(2);
        issue(1, 2, 1, 32'hFFFF_FFFC, 32'h0, acc);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            if (cyc > MAXC - 200) break;
            issue(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 3)), $urandom, $urandom, acc);
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
        end

        REQ_VALID = 1'b0;
        w = 0;
        while (sb.size() > 0 && w < 200) begin
            @(negedge CLK);
            w++;
        end
        repeat (3) @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("accept_count", 32'(dut_acc), 32'(model_acc));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
